// File: rtl/simon_pkg.sv
// Shared Simon definitions: playback FSM state encoding and LED constants.
// Also used by the Simon control FSM, so the encoding must stay stable.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SHOW  = 3'd3,
    GAP   = 3'd4,
    FIN   = 3'd5
  } simon_state_e;

  localparam logic [3:0] LED_BLANK = 4'b0000;

endpackage

// File: rtl/simon_playback_sequencer_if.sv
// Signal bundle between the playback sequencer, the Simon control FSM,
// the pattern memory read port and the LED drivers.
//
// Handshake: the control FSM raises start for one cycle, with len valid in
// that same cycle. The request is taken only when busy is low; start while
// busy is high is dropped, not queued. Completion is the one-cycle done
// pulse, and busy drops in the following cycle. abort is a level that
// overrides everything in the cycle it is sampled. Memory reads have no
// back-pressure: pattern_in must be valid the cycle after rd_en.
interface simon_playback_sequencer_if #(
  parameter int ADDR_W = 9
);
  import simon_pkg::*;

  logic              start;
  logic              abort;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        pattern_in;
  logic [3:0]        leds;
  simon_state_e      dbg_state;

  // Environment side: control FSM, pattern memory and LED drivers
  modport master (
    output start, abort, len, pattern_in,
    input  busy, done, rd_en, rd_addr, leds, dbg_state
  );

  // Sequencer side
  modport slave (
    input  start, abort, len, pattern_in,
    output busy, done, rd_en, rd_addr, leds, dbg_state
  );

endinterface

// File: rtl/simon_interval_timer.sv
// Loadable down-counter timing the SHOW and GAP intervals.
// load wins over dec; dec saturates at zero so a stray decrement never wraps.
module simon_interval_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Next count: load, else saturating decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  // Count register, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Plays pattern memory entries 0..len-1 onto the LEDs: each entry is fetched,
// shown for ON_CYCLES clocks, then blanked for OFF_CYCLES clocks; a one-cycle
// done follows the last gap. abort returns to IDLE at once with LEDs blank.
module simon_playback_sequencer
  import simon_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int TIMER_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  simon_playback_sequencer_if.slave  bus
);

  // Timer is loaded with N-1 so that the interval spans exactly N cycles
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [ADDR_W:0]    IDX_ONE  = (ADDR_W + 1)'(1);

  simon_state_e       state_q, state_d;
  // idx is one bit wider than the address so len = 2^ADDR_W needs no wrap
  logic [ADDR_W:0]    idx_q, idx_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [3:0]         leds_q, leds_d;
  logic               done_q, done_d;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               last_entry;

  assign last_entry = (idx_q == (len_q - IDX_ONE));

  simon_interval_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      leds_q  <= LED_BLANK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

  // Next-state decode; abort overrides every state
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = (bus.len == '0) ? FIN : FETCH;
        FETCH:   state_d = LATCH;
        LATCH:   state_d = SHOW;
        SHOW:    if (tmr_zero) state_d = GAP;
        GAP:     if (tmr_zero) state_d = last_entry ? FIN : FETCH;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values, registered LED/done outputs and timer control
  always_comb begin
    idx_d        = idx_q;
    len_d        = len_q;
    leds_d       = leds_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = ON_LOAD;
    tmr_dec      = 1'b0;
    if (bus.abort) begin
      leds_d = LED_BLANK;
      len_d  = '0;
      idx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_d  = bus.len;
            idx_d  = '0;
            done_d = (bus.len == '0);
          end
        end
        LATCH: begin
          leds_d       = bus.pattern_in;
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
        SHOW: begin
          if (tmr_zero) begin
            leds_d       = LED_BLANK;
            tmr_load     = 1'b1;
            tmr_load_val = OFF_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        GAP: begin
          if (tmr_zero) begin
            if (last_entry) begin
              done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.leds      = leds_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = (state_q == FETCH);
  assign bus.rd_addr   = idx_q[ADDR_W-1:0];
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Bench for the Simon playback sequencer. A timeline model predicts, for
// every cycle, rd_en/rd_addr/leds/busy/done from the playback rules; a
// second small instance (ADDR_W=2) covers the full-length no-wrap case.
`timescale 1ns/1ps
module tb_simon_playback_sequencer;
  import simon_pkg::*;

  localparam int ADDR_W = 9;
  localparam int ON     = 3;
  localparam int OFF    = 2;
  localparam int PER    = 2 + ON + OFF;
  localparam int MAXC   = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  simon_playback_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  simon_playback_sequencer_if #(.ADDR_W(2))      bus2 ();

  simon_playback_sequencer #(
    .ADDR_W(ADDR_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMER_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  simon_playback_sequencer #(
    .ADDR_W(2), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMER_W(16)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // ---------------- pattern memories (synchronous read) ----------------
  logic [3:0] mem  [1 << ADDR_W];
  logic [3:0] mem2 [4];

  always @(posedge clk) begin
    if (!rst)            bus.pattern_in <= 4'h0;
    else if (bus.rd_en)  bus.pattern_in <= mem[bus.rd_addr];
  end

  always @(posedge clk) begin
    if (!rst)            bus2.pattern_in <= 4'h0;
    else if (bus2.rd_en) bus2.pattern_in <= mem2[bus2.rd_addr];
  end

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, want);
    end
  endtask

  // ---------------- timeline model ----------------
  logic              m_rden [MAXC];
  logic [ADDR_W-1:0] m_addr [MAXC];
  logic [3:0]        m_leds [MAXC];
  logic              m_busy [MAXC];
  logic              m_done [MAXC];

  task automatic model_clear(input int from);
    for (int i = from; i < MAXC; i++) begin
      m_rden[i] = 1'b0;
      m_addr[i] = '0;
      m_leds[i] = 4'h0;
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  // Playback accepted at edge s: entry k fetched in cycle s+k*PER, shown
  // from s+k*PER+2 for ON cycles; done in cycle s+len*PER.
  task automatic model_fill(input int s, input int l);
    if (l == 0) begin
      m_busy[s] = 1'b1;
      m_done[s] = 1'b1;
    end else begin
      for (int k = 0; k < l; k++) begin
        m_rden[s + k*PER] = 1'b1;
        m_addr[s + k*PER] = ADDR_W'(k);
        for (int j = 0; j < ON; j++) m_leds[s + k*PER + 2 + j] = mem[k];
      end
      for (int i = s; i <= s + l*PER; i++) m_busy[i] = 1'b1;
      m_done[s + l*PER] = 1'b1;
    end
  endtask

  // ---------------- compare process ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && (cyc < MAXC)) begin
      check("rd_en", 32'(bus.rd_en), 32'(m_rden[cyc]));
      if (m_rden[cyc]) check("rd_addr", 32'(bus.rd_addr), 32'(m_addr[cyc]));
      check("leds", 32'(bus.leds), 32'(m_leds[cyc]));
      check("busy", 32'(bus.busy), 32'(m_busy[cyc]));
      check("done", 32'(bus.done), 32'(m_done[cyc]));
    end
  end

  // ---------------- scoreboard for the ADDR_W=2 instance ----------------
  logic [1:0] exp_q[$];
  logic [3:0] exp_led_q[$];
  logic [1:0] a2;
  logic [3:0] l2;
  logic [3:0] prev_leds2 = 4'h0;
  int         done2_cnt  = 0;

  always @(negedge clk) begin
    if (bus2.rd_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_addr2_extra cyc=%0d got=%0h expected=none", cyc, bus2.rd_addr);
      end else begin
        a2 = exp_q.pop_front();
        check("rd_addr2", 32'(bus2.rd_addr), 32'(a2));
      end
    end
    if ((bus2.leds != prev_leds2) && (bus2.leds != 4'h0)) begin
      if (exp_led_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL leds2_extra cyc=%0d got=%0h expected=none", cyc, bus2.leds);
      end else begin
        l2 = exp_led_q.pop_front();
        check("leds2", 32'(bus2.leds), 32'(l2));
      end
    end
    prev_leds2 = bus2.leds;
    if (bus2.done) done2_cnt++;
  end

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic pulse_start(input int l, input bit with_abort, output int s);
    bus.start = 1'b1;
    bus.len   = (ADDR_W + 1)'(l);
    bus.abort = with_abort;
    s = cyc + 1;
    if (with_abort)         model_clear(s);
    else if (!m_busy[s-1])  model_fill(s, l);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    model_clear(cyc + 1);
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  // Hand-computed trace for memory {1, 4}, len=2, relative to FETCH cycle
  logic [15:0] lit_rden = 16'h0081;
  logic [15:0] lit_done = 16'h4000;
  logic [15:0] lit_busy = 16'h7FFF;
  logic [3:0]  lit_leds [16] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};

  // ---------------- main sequence ----------------
  int s, s2;
  initial begin
    rst = 1'b1;
    bus.start  = 1'b0; bus.abort  = 1'b0; bus.len  = '0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.len = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 4'(i * 3 + 1);
    mem[0] = 4'h1; mem[1] = 4'h4; mem[2] = 4'hA;
    mem2[0] = 4'h3; mem2[1] = 4'h5; mem2[2] = 4'h9; mem2[3] = 4'hC;
    model_clear(0);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_leds",  32'(bus.leds),    32'h0);
    check("rst_rd_en", 32'(bus.rd_en),   32'h0);
    check("rst_addr",  32'(bus.rd_addr), 32'h0);
    check("rst_busy",  32'(bus.busy),    32'h0);
    check("rst_done",  32'(bus.done),    32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));

    // Two-entry playback against the hand-computed trace
    pulse_start(2, 1'b0, s);
    for (int t = 0; t < 16; t++) begin
      check("lit_rd_en", 32'(bus.rd_en), 32'(lit_rden[t]));
      check("lit_leds",  32'(bus.leds),  32'(lit_leds[t]));
      check("lit_done",  32'(bus.done),  32'(lit_done[t]));
      check("lit_busy",  32'(bus.busy),  32'(lit_busy[t]));
      if (t == 0) check("lit_rd_addr0", 32'(bus.rd_addr), 32'd0);
      if (t == 7) check("lit_rd_addr1", 32'(bus.rd_addr), 32'd1);
      @(negedge clk);
    end

    // len=0: done in the cycle after the accepting edge, no reads
    pulse_start(0, 1'b0, s);
    check("len0_done",  32'(bus.done),  32'h1);
    check("len0_rd_en", 32'(bus.rd_en), 32'h0);
    @(negedge clk);
    check("len0_busy_after", 32'(bus.busy), 32'h0);
    check("len0_done_after", 32'(bus.done), 32'h0);
    repeat (2) @(negedge clk);

    // Second start during SHOW is ignored; done still lands at t=14
    pulse_start(2, 1'b0, s);
    repeat (3) @(negedge clk);
    pulse_start(5, 1'b0, s2);
    repeat (10) @(negedge clk);
    check("restart_done_t14", 32'(bus.done), 32'h1);
    repeat (3) @(negedge clk);

    // Abort during the GAP of entry 0, then a fresh start replays from addr 0
    pulse_start(3, 1'b0, s);
    repeat (5) @(negedge clk);
    pulse_abort();
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_leds", 32'(bus.leds), 32'h0);
    repeat (25) @(negedge clk);
    pulse_start(3, 1'b0, s);
    check("replay_rd_en",  32'(bus.rd_en),   32'h1);
    check("replay_addr0",  32'(bus.rd_addr), 32'h0);
    repeat (3 * PER + 3) @(negedge clk);

    // start and abort together in IDLE: abort wins
    pulse_start(2, 1'b1, s);
    check("start_abort_busy", 32'(bus.busy), 32'h0);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of SHOW
    pulse_start(2, 1'b0, s);
    repeat (3) @(negedge clk);
    check("pre_reset_leds", 32'(bus.leds), 32'h1);
    #1 rst = 1'b0;
    model_clear(cyc + 1);
    #1;
    check("async_rst_leds",  32'(bus.leds),    32'h0);
    check("async_rst_rd_en", 32'(bus.rd_en),   32'h0);
    check("async_rst_addr",  32'(bus.rd_addr), 32'h0);
    check("async_rst_busy",  32'(bus.busy),    32'h0);
    check("async_rst_done",  32'(bus.done),    32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    repeat (2) @(negedge clk);

    // Small instance: len = 2^ADDR_W plays 0..3 with no wrap, one done
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(2'(i));
      exp_led_q.push_back(mem2[i]);
    end
    bus2.len   = 3'b100;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (4 * PER + 4) @(negedge clk);
    check("full_done_count", 32'(done2_cnt),          32'd1);
    check("full_addr_left",  32'(exp_q.size()),       32'd0);
    check("full_leds_left",  32'(exp_led_q.size()),   32'd0);
    check("full_busy_end",   32'(bus2.busy),          32'h0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_playback_sequencer.md
# simon_playback_sequencer

Paces the playback of a stored Simon pattern sequence onto the game LEDs. On a start pulse it reads pattern memory entries 0..len-1 through a synchronous-read port and shows each entry for `ON_CYCLES` clocks, then blanks the LEDs for `OFF_CYCLES` clocks. After the last entry it emits a one-cycle `done`. It sits between the Simon control FSM, which issues `start`/`abort` and waits for `done`, and the pattern memory / LED drivers of the datapath.

## Interface
Parameters:
- `ADDR_W`, 9: pattern memory address width; max sequence length is 2^ADDR_W.
- `ON_CYCLES`, 4: clocks each pattern is displayed; must be ≥1.
- `OFF_CYCLES`, 2: blank clocks after each pattern; must be ≥1.
- `TIMER_W`, 16: interval timer width; must satisfy ON_CYCLES, OFF_CYCLES ≤ 2^TIMER_W.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin playback; sampled only in IDLE.
- `abort`  in  1  cancel playback immediately; has priority over all other inputs.
- `len`  in  ADDR_W+1  number of entries to play, 0..2^ADDR_W; captured on accepted `start`.
- `rd_en`  out  1  pattern memory read strobe.
- `rd_addr`  out  ADDR_W  pattern memory read address.
- `pattern_in`  in  4  memory read data, valid the cycle after `rd_en`.
- `leds`  out  4  displayed pattern; 0 when blank.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final gap; also pulses for len=0.

## Operation
- States: IDLE, FETCH, LATCH, SHOW, GAP, FIN.
- IDLE:
  - On `start`=1, capture `len` and clear the index `idx`.
  - If len=0, go to FIN. Otherwise go to FETCH.
- FETCH:
  - `rd_en`=1 and `rd_addr`=idx, for exactly one cycle.
  - Go to LATCH.
- LATCH:
  - `leds` <= `pattern_in` at the closing edge.
  - Timer <= ON_CYCLES-1.
  - Go to SHOW.
- SHOW:
  - `leds` holds the latched pattern.
  - Timer decrements each cycle.
  - When timer=0: `leds` <= 0, timer <= OFF_CYCLES-1, go to GAP.
- GAP:
  - `leds`=0. Timer decrements each cycle.
  - When timer=0: if idx=len-1, go to FIN. Otherwise idx <= idx+1 and go to FETCH.
- FIN:
  - `done`=1 for one cycle.
  - Go to IDLE.
- `abort`=1 in any state: next state IDLE, `leds` <= 0, no `done`; the captured len is discarded.
- `start` outside IDLE is ignored. `start` and `abort` in the same cycle in IDLE: abort wins, stay IDLE.
- idx is ADDR_W+1 bits internally; `rd_addr` is its low ADDR_W bits. len=2^ADDR_W plays all addresses with no wrap.
- `rd_addr` outside FETCH holds idx; memory ignores it while `rd_en`=0.

## Timing
- Reset (`rst`=0, asynchronous) forces state IDLE and sets `leds`=0, `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0, idx=0, timer=0. Release is synchronous to `clk`.
- `leds` and `done` are registered outputs. `rd_en`, `rd_addr` and `busy` are decoded from state and registers, so they are glitch-free at clock edges.
- `start` accepted at edge E: FETCH occupies cycle E+1 and `leds` becomes valid after edge E+2.
- Per-entry period is 2 + ON_CYCLES + OFF_CYCLES cycles.
- len=N≥1: `done` asserts N·(2+ON+OFF)+1 cycles after the accepting edge.
- len=0: `done` asserts in the cycle after the accepting edge.
- `busy` falls in the cycle after `done`. A new `start` may be accepted in that same cycle.
- `abort` registered at edge A: `busy`=0 and `leds`=0 from A onward.

## Structure
- Shared package `simon_pkg`: state encoding enum (IDLE=0 … FIN=5, 3 bits) and the LED_BLANK=4'b0000 constant. The package is shared with the Simon control FSM.
- One sub-module, `simon_interval_timer`: loadable TIMER_W down-counter with `load`, `load_val`, `dec` inputs and a `zero` flag. It is instantiated once and serves both the SHOW and GAP intervals.

## Test plan
All scenarios use ON=3, OFF=2.
- Reset mid-SHOW: assert `rst`=0 asynchronously → all outputs 0 before the next edge, state IDLE after release.
- Memory {0:4'b0001, 1:4'b0100}, len=2, start at edge 0 → `rd_en`@1 addr0, `leds`=0001 cycles 3–5, 0 cycles 6–7, `rd_en`@8 addr1, `leds`=0100 cycles 10–12, `done`@15, `busy`=0@16.
- len=0 start → `done` next cycle, `rd_en` never asserted, `leds` stays 0.
- Start pulsed again during SHOW → ignored. Sequence and `done` timing are identical to the single-start run.
- Abort during GAP of entry 0 (len=3) → `busy`=0 and `leds`=0 next cycle, no `done`, no further `rd_en`. A fresh start then replays from addr 0.
- ADDR_W=2, len=4 → addresses 0,1,2,3 read in order, no wrap to 0, one `done`.
